pad_layer_scheduler: RTL and testbench

Sequences the padding write controller across consecutive layers.
- Accepts layer descriptors (OFM_C, OFM_W, padding) into a small FIFO.
- For each layer: configures the padding controller, pulses its start, and gates and counts the PE-array output beats.
- After a fixed drain, signals layer completion and toggles the ping-pong output-buffer bank.
- Sits between the layer-config host/loader and the padding controller.

---
 rtl/pad_sched_pkg.sv | 42 ++++
 rtl/pad_desc_fifo.sv | 58 +++++
 rtl/pad_layer_scheduler.sv | 164 ++++++++++++++++
 tb/tb_pad_layer_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_sched_pkg.sv
`timescale 1ns/1ps
// pad_sched_pkg
// Shared types and constants for the padding layer scheduler:
//   sched_state_t  - scheduler FSM state encoding (3-bit)
//   layer_desc_t   - one queued layer descriptor {c, w, pad}
//   BEAT_CNT_W     - width of the per-layer beat counter
//   PE_SHIFT       - log2 of the default lane count
//   layer_beats()  - number of PE-array beats a layer produces
package pad_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] w;
    logic       pad;
  } layer_desc_t;

  localparam int BEAT_CNT_W = 32;
  localparam int PE_DEFAULT = 16;

  function automatic int log2_pe(input int pe);
    return $clog2(pe);
  endfunction

  localparam int PE_SHIFT = log2_pe(PE_DEFAULT);

  // C*W*W always fits in 24 bits for 8-bit C and W; each beat carries PE values.
  function automatic logic [BEAT_CNT_W-1:0] layer_beats(input layer_desc_t d, input int shift);
    logic [23:0] prod;
    prod = 24'(d.c) * 24'(d.w) * 24'(d.w);
    return {8'd0, prod} >> shift;
  endfunction

endpackage

// File: rtl/pad_desc_fifo.sv
`timescale 1ns/1ps
// pad_desc_fifo
// Synchronous show-ahead FIFO of layer descriptors.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (flushes the FIFO)
//   push, wdata  write request / descriptor (ignored while full)
//   pop          read request (ignored while empty); rdata is the head entry
//   full, empty  occupancy flags
module pad_desc_fifo
  import pad_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  layer_desc_t wdata,
  input  logic        pop,
  output layer_desc_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  layer_desc_t mem_r [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  // Flag and handshake decode.
  always_comb begin
    full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    empty   = (wr_ptr_r == rd_ptr_r);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    rdata   = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pad_layer_scheduler.sv
`timescale 1ns/1ps
// pad_layer_scheduler
// Sequences the padding write controller over queued layers: pops a
// descriptor, configures the controller, pulses pad_start, forwards and
// counts PE-array beats, drains, then flags layer_done and flips bank_sel.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   desc_valid/desc_ready      descriptor push handshake (desc_c/desc_w/desc_pad)
//   ofm_valid_in               beat valid from the PE array
//   pad_valid, pad_start       beat valid / start pulse to the padding controller
//   pad_ofm_c/w, pad_padding   layer configuration to the padding controller
//   bank_sel                   ping-pong output bank being written
//   layer_done, busy           completion pulse / scheduler active
//   err_overrun                sticky: beat seen outside RUN
//   perf_cycles                (only with PAD_SCHED_PERF_EN) START+RUN+DRAIN cycles of last layer
module pad_layer_scheduler
  import pad_sched_pkg::*;
#(
  parameter int PE           = PE_DEFAULT,
  parameter int DESC_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       desc_valid,
  output logic       desc_ready,
  input  logic [7:0] desc_c,
  input  logic [7:0] desc_w,
  input  logic       desc_pad,
  input  logic       ofm_valid_in,
  output logic       pad_valid,
  output logic       pad_start,
  output logic [7:0] pad_ofm_c,
  output logic [7:0] pad_ofm_w,
  output logic       pad_padding,
  output logic       bank_sel,
  output logic       layer_done,
  output logic       busy,
  output logic       err_overrun
`ifdef PAD_SCHED_PERF_EN
  , output logic [31:0] perf_cycles
`endif
);

  localparam int SHIFT = log2_pe(PE);
  localparam int DW    = $clog2(DRAIN_CYCLES + 1);

  sched_state_t          state_r, state_nxt;
  layer_desc_t           fifo_wdata, fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [BEAT_CNT_W-1:0] expected_r;
  logic [BEAT_CNT_W-1:0] beat_cnt_r;
  logic [DW-1:0]         drain_cnt_r;

  assign fifo_wdata = '{c: desc_c, w: desc_w, pad: desc_pad};

  pad_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (desc_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt  = state_r;
    fifo_pop   = 1'b0;
    pad_start  = 1'b0;
    pad_valid  = 1'b0;
    layer_done = 1'b0;
    busy       = (state_r != ST_IDLE);
    desc_ready = !fifo_full;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_LOAD;
        else             state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        fifo_pop  = 1'b1;
        state_nxt = ST_START;
      end
      ST_START: begin
        pad_start = 1'b1;
        if (expected_r == 32'd0) state_nxt = ST_DRAIN;
        else                     state_nxt = ST_RUN;
      end
      ST_RUN: begin
        pad_valid = ofm_valid_in;
        if (ofm_valid_in && (beat_cnt_r == expected_r - 32'd1)) state_nxt = ST_DRAIN;
        else                                                    state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DW'(DRAIN_CYCLES - 1)) state_nxt = ST_DONE;
        else                                      state_nxt = ST_DRAIN;
      end
      ST_DONE: begin
        layer_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt;
  end

  // Layer configuration, beat/drain counters, bank and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_ofm_c   <= 8'd0;
      pad_ofm_w   <= 8'd0;
      pad_padding <= 1'b0;
      expected_r  <= 32'd0;
      beat_cnt_r  <= 32'd0;
      drain_cnt_r <= '0;
      bank_sel    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (state_r == ST_LOAD) begin
        pad_ofm_c   <= fifo_rdata.c;
        pad_ofm_w   <= fifo_rdata.w;
        pad_padding <= fifo_rdata.pad;
        expected_r  <= layer_beats(fifo_rdata, SHIFT);
        beat_cnt_r  <= 32'd0;
      end else if ((state_r == ST_RUN) && ofm_valid_in) begin
        beat_cnt_r <= beat_cnt_r + 32'd1;
      end
      // Counter restarts whenever DRAIN is not active, so each entry starts at 0.
      if (state_r == ST_DRAIN) drain_cnt_r <= drain_cnt_r + 1'b1;
      else                     drain_cnt_r <= '0;
      if (state_r == ST_DONE) bank_sel <= ~bank_sel;
      if (ofm_valid_in && (state_r != ST_RUN)) err_overrun <= 1'b1;
    end
  end

`ifdef PAD_SCHED_PERF_EN
  logic [31:0] perf_acc_r;

  // Active-cycle accumulator, published when the layer completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_acc_r  <= 32'd0;
      perf_cycles <= 32'd0;
    end else begin
      case (state_r)
        ST_LOAD:                    perf_acc_r <= 32'd0;
        ST_START, ST_RUN, ST_DRAIN: if (perf_acc_r != 32'hFFFF_FFFF) perf_acc_r <= perf_acc_r + 32'd1;
        ST_DONE:                    perf_cycles <= perf_acc_r;
        default:                    perf_acc_r <= perf_acc_r;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pad_layer_scheduler.sv
`timescale 1ns/1ps
module tb_pad_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       desc_valid = 1'b0;
  logic       desc_ready;
  logic [7:0] desc_c = 8'd0;
  logic [7:0] desc_w = 8'd0;
  logic       desc_pad = 1'b0;
  logic       ofm_valid_in = 1'b0;
  logic       pad_valid, pad_start, pad_padding, bank_sel, layer_done, busy, err_overrun;
  logic [7:0] pad_ofm_c, pad_ofm_w;
`ifdef PAD_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  pad_layer_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_c       (desc_c),
    .desc_w       (desc_w),
    .desc_pad     (desc_pad),
    .ofm_valid_in (ofm_valid_in),
    .pad_valid    (pad_valid),
    .pad_start    (pad_start),
    .pad_ofm_c    (pad_ofm_c),
    .pad_ofm_w    (pad_ofm_w),
    .pad_padding  (pad_padding),
    .bank_sel     (bank_sel),
    .layer_done   (layer_done),
    .busy         (busy),
    .err_overrun  (err_overrun)
`ifdef PAD_SCHED_PERF_EN
    , .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int c;
    int w;
    int pad;
    int bank;
    int beats;
    int gap;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_start(input int c, input int w, input int pad);
    sb.push_back('{is_done: 1'b0, c: c, w: w, pad: pad, bank: 0, beats: 0, gap: 0});
  endtask

  task automatic exp_done(input int bank, input int beats, input int gap);
    sb.push_back('{is_done: 1'b1, c: 0, w: 0, pad: 0, bank: bank, beats: beats, gap: gap});
  endtask

  task automatic push(input int c, input int w, input int pad);
    desc_c = 8'(c);
    desc_w = 8'(w);
    desc_pad = pad[0];
    desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_start(output int k);
    k = 0;
    while (!pad_start && k < 300) begin
      tick();
      k++;
    end
    chk("start_seen", {31'd0, pad_start}, 32'd1);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!layer_done && k < 300) begin
      tick();
      k++;
    end
    chk("done_seen", {31'd0, layer_done}, 32'd1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals start or completion.
  int  beat_cnt = 0;
  int  start_cyc = 0;
  bit  perf_pend = 1'b0;
  int  perf_exp = 0;
  ev_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      beat_cnt = 0;
      perf_pend = 1'b0;
    end else begin
`ifdef PAD_SCHED_PERF_EN
      if (perf_pend) chk("perf_cycles", perf_cycles, 32'(perf_exp));
`endif
      perf_pend = 1'b0;
      if (pad_valid) beat_cnt++;
      if (pad_start) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: got c=%0d expected no start", pad_ofm_c);
        end else begin
          e = sb.pop_front();
          chk("start_order", {31'd0, e.is_done}, 32'd0);
          chk("start_c", {24'd0, pad_ofm_c}, 32'(e.c));
          chk("start_w", {24'd0, pad_ofm_w}, 32'(e.w));
          chk("start_pad", {31'd0, pad_padding}, 32'(e.pad));
        end
        beat_cnt = 0;
        start_cyc = cyc;
      end
      if (layer_done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got layer_done=1 expected none");
        end else begin
          e = sb.pop_front();
          chk("done_order", {31'd0, e.is_done}, 32'd1);
          chk("done_bank", {31'd0, bank_sel}, 32'(e.bank));
          chk("done_beats", 32'(beat_cnt), 32'(e.beats));
          chk("done_gap", 32'(cyc - start_cyc), 32'(e.gap));
          perf_exp = e.gap;
          perf_pend = 1'b1;
        end
      end
    end
  end

  int k;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_desc_ready", {31'd0, desc_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outs", {pad_ofm_c, pad_ofm_w, 11'd0, pad_padding, bank_sel, layer_done, err_overrun, pad_start}, 32'd0);
`ifdef PAD_SCHED_PERF_EN
    chk("rst_perf", perf_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single layer: 16*4*4 >> 4 = 16 beats, 1 START + 16 RUN + 8 DRAIN
    exp_start(16, 4, 1);
    exp_done(0, 16, 25);
    push(16, 4, 1);
    wait_start(k);
    chk("start_latency", 32'(k + 1), 32'd3);
    tick();
    ofm_valid_in = 1'b1;
    repeat (16) tick();
    ofm_valid_in = 1'b0;
    wait_done(k);
    chk("drain_len", 32'(k), 32'd8);
    chk("bank_during_done", {31'd0, bank_sel}, 32'd0);
    tick();
    chk("bank_after_done", {31'd0, bank_sel}, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_one_pulse", {31'd0, layer_done}, 32'd0);
    chk("no_overrun_yet", {31'd0, err_overrun}, 32'd0);

    // Overrun in IDLE and during DRAIN
    ofm_valid_in = 1'b1;
    #1;
    chk("idle_pad_valid", {31'd0, pad_valid}, 32'd0);
    tick();
    ofm_valid_in = 1'b0;
    chk("overrun_set", {31'd0, err_overrun}, 32'd1);
    exp_start(16, 4, 0);
    exp_done(1, 16, 25);
    push(16, 4, 0);
    wait_start(k);
    tick();
    ofm_valid_in = 1'b1;
    repeat (16) tick();
    #1;
    chk("drain_pad_valid", {31'd0, pad_valid}, 32'd0);
    repeat (2) tick();
    ofm_valid_in = 1'b0;
    wait_done(k);
    tick();
    chk("overrun_sticky", {31'd0, err_overrun}, 32'd1);

    // Zero-beat layer: 1*2*2 >> 4 = 0
    exp_start(1, 2, 1);
    exp_done(0, 0, 9);
    push(1, 2, 1);
    wait_start(k);
    wait_done(k);
    chk("zero_done_after_start", 32'(k), 32'd9);
    tick();

    // FIFO full during a long layer (16*8*8 >> 4 = 64 beats)
    exp_start(16, 8, 1);
    exp_done(1, 64, 73);
    push(16, 8, 1);
    wait_start(k);
    ofm_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", {31'd0, desc_ready}, (i < 4) ? 32'd1 : 32'd0);
      case (i)
        0: begin exp_start(2, 4, 0); exp_done(0, 2, 11); desc_c = 8'd2; desc_w = 8'd4; desc_pad = 1'b0; end
        1: begin exp_start(3, 4, 1); exp_done(1, 3, 12); desc_c = 8'd3; desc_w = 8'd4; desc_pad = 1'b1; end
        2: begin exp_start(1, 4, 0); exp_done(0, 1, 10); desc_c = 8'd1; desc_w = 8'd4; desc_pad = 1'b0; end
        3: begin exp_start(4, 2, 1); exp_done(1, 1, 10); desc_c = 8'd4; desc_w = 8'd2; desc_pad = 1'b1; end
        default: begin desc_c = 8'd9; desc_w = 8'd9; desc_pad = 1'b1; end
      endcase
      desc_valid = 1'b1;
      tick();
    end
    desc_valid = 1'b0;
    chk("full_ready", {31'd0, desc_ready}, 32'd0);
    k = 0;
    while (sb.size() != 0 && k < 600) begin
      tick();
      k++;
    end
    chk("fifo_layers_all_done", 32'(sb.size()), 32'd0);
    ofm_valid_in = 1'b0;
    repeat (5) tick();
    chk("fifo_final_busy", {31'd0, busy}, 32'd0);
    chk("fifo_final_bank", {31'd0, bank_sel}, 32'd0);

    // Reset after beat 7 of 16 with a second descriptor still queued
    exp_start(16, 4, 1);
    push(16, 4, 1);
    push(2, 2, 0);
    wait_start(k);
    tick();
    ofm_valid_in = 1'b1;
    repeat (7) tick();
    ofm_valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_desc_ready", {31'd0, desc_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cfg", {16'd0, pad_ofm_c, pad_ofm_w}, 32'd0);
    chk("mid_rst_flags", {26'd0, pad_padding, bank_sel, layer_done, err_overrun, pad_start, pad_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("post_rst_fifo_empty", {31'd0, busy}, 32'd0);
    chk("post_rst_ready", {31'd0, desc_ready}, 32'd1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
